// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset address and fetch state encoding for the CPU front end
package cpu_pkg;
   localparam int ADDR_W = 24;
   localparam int INSTR_W = 24;
   localparam int INSTR_BYTES = 3;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 24'd10;
   typedef enum logic [1:0] {FETCH0, FETCH1, FETCH2, HOLD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory byte bus, branch redirect and instruction ready/valid bundle
interface instr_fetch_if;
   import cpu_pkg::*;
   logic mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic mem_ack;
   logic [7:0] mem_rdata;
   logic branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic instr_valid;
   logic instr_ready;
   modport master (
      output mem_req, mem_addr, instr, instr_pc, instr_valid,
      input mem_ack, mem_rdata, branch_taken, branch_target, instr_ready
   );
   modport slave (
      input mem_req, mem_addr, instr, instr_pc, instr_valid,
      output mem_ack, mem_rdata, branch_taken, branch_target, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches three-byte big-endian instructions and presents them over ready/valid
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic clock,
   input logic reset_n,
   instr_fetch_if.master bus
);
   fetch_state_t state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [INSTR_W-9:0] hi;
   assign pc_next = pc + ADDR_W'(INSTR_BYTES);
   // mem_addr tracks PC+n by incrementing on each accepted byte
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= FETCH0;
         pc <= RESET_PC;
         hi <= '0;
         bus.instr <= '0;
         bus.instr_pc <= '0;
         bus.instr_valid <= 1'b0;
         bus.mem_req <= 1'b0;
         bus.mem_addr <= RESET_PC;
      end else if (bus.branch_taken) begin
         state <= FETCH0;
         pc <= bus.branch_target;
         bus.instr_valid <= 1'b0;
         bus.mem_req <= 1'b1;
         bus.mem_addr <= bus.branch_target;
      end else
         case (state)
            FETCH0, FETCH1, FETCH2: begin
               bus.mem_req <= 1'b1;
               if (bus.mem_req && bus.mem_ack) begin
                  if (state == FETCH2) begin
                     bus.instr <= {hi, bus.mem_rdata};
                     bus.instr_pc <= pc;
                     bus.instr_valid <= 1'b1;
                     bus.mem_req <= 1'b0;
                     state <= HOLD;
                  end else begin
                     hi <= state == FETCH0 ? {bus.mem_rdata, hi[7:0]} : {hi[15:8], bus.mem_rdata};
                     bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                     state <= state == FETCH0 ? FETCH1 : FETCH2;
                  end
               end
            end
            HOLD:
               if (bus.instr_ready) begin
                  state <= FETCH0;
                  pc <= pc_next;
                  bus.instr_valid <= 1'b0;
                  bus.mem_req <= 1'b1;
                  bus.mem_addr <= pc_next;
               end
            default: begin
               state <= FETCH0;
               bus.instr_valid <= 1'b0;
               bus.mem_req <= 1'b1;
               bus.mem_addr <= pc;
            end
         endcase
endmodule
